vec_addsub_pipe: RTL and testbench

- Parametrised, 2-stage pipelined SIMD integer add/subtract unit for the vector execution unit.
- Splits a DATA_W-bit datapath into byte slices and gates the carry at 8/16/32/64-bit element boundaries according to SEW.
- Supports plain, carry-in/borrow-in and saturating ops, with a valid/ready handshake on input and output.
- Sits between operand read and the VRF writeback arbiter.

---
 rtl/vec_addsub_pipe.sv | 170 +++++++++++++++++
 tb/tb_vec_addsub_pipe.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_addsub_pipe.sv
// Two-stage SIMD add/subtract unit: byte-sliced carry chain segmented at SEW
// element boundaries, with carry/borrow-in and saturating variants.
module vec_addsub_pipe #(
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [1:0]          in_sew,
  input  logic [2:0]          in_op,
  input  logic [DATA_W/8-1:0] in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W/8-1:0] out_carry,
  output logic                out_sat
);
  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NB);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_RSUB  = 3'b010,
    OP_ADC   = 3'b011,
    OP_SBC   = 3'b100,
    OP_SADDU = 3'b101,
    OP_SADD  = 3'b110,
    OP_SSUB  = 3'b111
  } op_e;

  logic              r_v1, r_v2;
  logic [DATA_W-1:0] r_a1, r_b1, r_res2;
  logic [1:0]        r_sew1;
  op_e               r_op1;
  logic [NB-1:0]     r_cin1, r_carry2;
  logic              r_sat2;

  logic              w_load1, w_load2;
  logic [DATA_W-1:0] w_x, w_y, w_sum, w_res;
  logic              w_sub, w_sat_any;
  logic [NB-1:0]     w_init_c, w_ecout, w_eovf, w_easign;
  logic [IW-1:0]     w_mask;

  assign w_load2  = r_v1 && (!r_v2 || out_ready);
  assign w_load1  = !r_v1 || w_load2;
  assign in_ready = w_load1 && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_sew1 <= '0;
      r_op1  <= OP_ADD;
      r_cin1 <= '0;
    end else if (w_load1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a1   <= in_a;
        r_b1   <= in_b;
        r_sew1 <= in_sew;
        r_op1  <= op_e'(in_op);
        r_cin1 <= in_cin;
      end
    end
  end

  // Subtract forms feed the inverted subtrahend; RSUB swaps the operands.
  always_comb begin
    w_x      = r_a1;
    w_y      = ~r_b1;
    w_sub    = 1'b1;
    w_init_c = '0;
    case (r_op1)
      OP_ADD, OP_ADC, OP_SADDU, OP_SADD: begin
        w_y   = r_b1;
        w_sub = 1'b0;
      end
      OP_RSUB: begin
        w_x = r_b1;
        w_y = ~r_a1;
      end
      default: ;
    endcase
    for (int e = 0; e < NB; e++) begin
      case (r_op1)
        OP_SUB, OP_RSUB, OP_SSUB: w_init_c[e] = 1'b1;
        OP_ADC:                   w_init_c[e] = r_cin1[e];
        OP_SBC:                   w_init_c[e] = ~r_cin1[e];
        default:                  w_init_c[e] = 1'b0;
      endcase
    end
  end

  always_comb begin
    logic          c_prev;
    logic          c_in;
    logic          sat_e;
    logic [8:0]    s9;
    logic [IW-1:0] kk;
    logic [IW-1:0] ei;
    c_prev    = 1'b0;
    c_in      = 1'b0;
    sat_e     = 1'b0;
    s9        = '0;
    kk        = '0;
    ei        = '0;
    w_mask    = IW'((1 << r_sew1) - 1);
    w_sum     = '0;
    w_ecout   = '0;
    w_eovf    = '0;
    w_easign  = '0;
    w_sat_any = 1'b0;
    // Carry chain: element boundaries restart with the op's initial carry.
    for (int k = 0; k < NB; k++) begin
      kk   = IW'(k);
      ei   = IW'(k >> r_sew1);
      c_in = ((kk & w_mask) == '0) ? w_init_c[ei] : c_prev;
      s9   = {1'b0, w_x[8*k +: 8]} + {1'b0, w_y[8*k +: 8]} + {8'b0, c_in};
      w_sum[8*k +: 8] = s9[7:0];
      c_prev = s9[8];
      if ((kk & w_mask) == w_mask) begin
        w_ecout[ei]  = s9[8] ^ w_sub;
        w_eovf[ei]   = (w_x[8*k+7] == w_y[8*k+7]) && (s9[7] != w_x[8*k+7]);
        w_easign[ei] = r_a1[8*k+7];
      end
    end
    w_res = w_sum;
    for (int k = 0; k < NB; k++) begin
      kk    = IW'(k);
      ei    = IW'(k >> r_sew1);
      sat_e = ((r_op1 == OP_SADDU) && w_ecout[ei]) ||
              (((r_op1 == OP_SADD) || (r_op1 == OP_SSUB)) && w_eovf[ei]);
      if (sat_e) begin
        w_sat_any = 1'b1;
        if (r_op1 == OP_SADDU)
          w_res[8*k +: 8] = 8'hFF;
        else if ((kk & w_mask) == w_mask)
          w_res[8*k +: 8] = w_easign[ei] ? 8'h80 : 8'h7F;
        else
          w_res[8*k +: 8] = w_easign[ei] ? 8'h00 : 8'hFF;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v2     <= 1'b0;
      r_res2   <= '0;
      r_carry2 <= '0;
      r_sat2   <= 1'b0;
    end else if (w_load2) begin
      r_v2     <= 1'b1;
      r_res2   <= w_res;
      r_carry2 <= w_ecout;
      r_sat2   <= w_sat_any;
    end else if (out_ready) begin
      r_v2 <= 1'b0;
    end
  end

  assign out_valid  = r_v2;
  assign out_result = r_res2;
  assign out_carry  = r_carry2;
  assign out_sat    = r_sat2;
endmodule

// File: tb/tb_vec_addsub_pipe.sv
// Self-checking bench for vec_addsub_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an element-level model.
module tb_vec_addsub_pipe;
  localparam int DW = 64;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [1:0]    in_sew = '0;
  logic [2:0]    in_op = '0;
  logic [NB-1:0] in_cin = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic [NB-1:0] out_carry;
  logic          out_sat;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  carry;
    logic        sat;
  } beat_t;

  typedef struct {
    beat_t b;
    int    lat;
    int    cyc;
  } log_t;

  beat_t exp_q[$];
  int    acc_q[$];
  log_t  out_log[$];

  vec_addsub_pipe #(.DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sew     (in_sew),
    .in_op      (in_op),
    .in_cin     (in_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Element-wise reference: each element handled as an independent integer.
  function automatic beat_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic [1:0] sew, input logic [2:0] op,
                                  input logic [7:0] cin);
    beat_t r;
    int w, ne;
    logic [67:0] m, ae, be, re, ci;
    logic signed [69:0] sa, sb, sr, smax, smin;
    logic c, s;
    logic [127:0] acc;
    w   = 8 << sew;
    ne  = 8 >> sew;
    m   = 68'd1 << w;
    acc = '0;
    r   = '0;
    for (int e = 0; e < ne; e++) begin
      ae = ({4'b0, a} >> (e * w)) & (m - 68'd1);
      be = ({4'b0, b} >> (e * w)) & (m - 68'd1);
      ci = {67'b0, cin[e]};
      sa = $signed({2'b0, ae});
      if (ae[w-1]) sa = sa - $signed({2'b0, m});
      sb = $signed({2'b0, be});
      if (be[w-1]) sb = sb - $signed({2'b0, m});
      smax = $signed({2'b0, m >> 1}) - 70'sd1;
      smin = -$signed({2'b0, m >> 1});
      sr = '0;
      s  = 1'b0;
      case (op)
        3'd0: begin re = ae + be; c = (re >= m); end
        3'd1: begin re = ae + m - be; c = (ae < be); end
        3'd2: begin re = be + m - ae; c = (be < ae); end
        3'd3: begin re = ae + be + ci; c = (re >= m); end
        3'd4: begin re = ae + m - be - ci; c = (ae < be + ci); end
        3'd5: begin
          re = ae + be;
          c  = (re >= m);
          if (c) begin re = m - 68'd1; s = 1'b1; end
        end
        3'd6: begin re = ae + be; c = (re >= m); sr = sa + sb; end
        default: begin re = ae + m - be; c = (ae < be); sr = sa - sb; end
      endcase
      if (op == 3'd6 || op == 3'd7) begin
        if (sr > smax) begin re = smax[67:0]; s = 1'b1; end
        else if (sr < smin) begin re = smin[67:0]; s = 1'b1; end
      end
      re = re & (m - 68'd1);
      acc = acc | ({60'b0, re} << (e * w));
      r.carry[e] = c;
      r.sat = r.sat | s;
    end
    r.res = acc[63:0];
    return r;
  endfunction

  logic        prev_stall = 1'b0;
  logic [72:0] prev_out = '0;
  beat_t       m_e;
  int          m_acc;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid)
        check_val("stall_hold", 128'({out_result, out_carry, out_sat}), 128'(prev_out));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", 128'(out_valid), 128'(0));
        end else begin
          m_e   = exp_q.pop_front();
          m_acc = acc_q.pop_front();
          check_val("result", 128'(out_result), 128'(m_e.res));
          check_val("carry", 128'(out_carry), 128'(m_e.carry));
          check_val("sat", 128'(out_sat), 128'(m_e.sat));
          out_log.push_back('{b: '{res: out_result, carry: out_carry, sat: out_sat},
                              lat: cyc - m_acc, cyc: cyc});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_sew, in_op, in_cin));
        acc_q.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_result, out_carry, out_sat};
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the beat is taken.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sew,
                      input logic [2:0] op, input logic [7:0] cin);
    in_a = a; in_b = b; in_sew = sew; in_op = op; in_cin = cin;
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check_val("send_timeout", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int k = 0; k < 60 && out_log.size() < n; k++) @(posedge clk);
    check_val("log_wait", 128'(out_log.size()), 128'(n));
    #1;
  endtask

  task automatic dir1(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] sew, input logic [2:0] op, input logic [7:0] cin,
                      input logic [63:0] er, input logic [7:0] ec, input logic es);
    int base;
    base = out_log.size();
    send(a, b, sew, op, cin);
    wait_log(base + 1);
    if (out_log.size() > base) begin
      check_val({tag, "_res"}, 128'(out_log[base].b.res), 128'(er));
      check_val({tag, "_carry"}, 128'(out_log[base].b.carry), 128'(ec));
      check_val({tag, "_sat"}, 128'(out_log[base].b.sat), 128'(es));
      check_val({tag, "_lat"}, 128'(out_log[base].lat), 128'(2));
    end
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] pats [4];
    pats[0] = 64'h7F7F_7F7F_7F7F_7F7F;
    pats[1] = 64'h8080_8080_8080_8080;
    pats[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    pats[3] = 64'h0000_0000_0000_0001;
    if ($urandom_range(3) == 0) return pats[$urandom_range(3)];
    return {$urandom(), $urandom()};
  endfunction

  int  base;
  bit  rand_done = 1'b0;

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_valid", 128'(out_valid), 128'(0));
    check_val("rst_result", 128'(out_result), 128'(0));
    check_val("rst_carry", 128'(out_carry), 128'(0));
    check_val("rst_sat", 128'(out_sat), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_val("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // back-to-back byte adds
    base = out_log.size();
    send(64'hFF, 64'h1, 2'b00, 3'd0, 8'h00);
    send(64'hFF, 64'h1, 2'b00, 3'd0, 8'h00);
    wait_log(base + 2);
    if (out_log.size() >= base + 2) begin
      for (int i = 0; i < 2; i++) begin
        check_val("b2b_res", 128'(out_log[base+i].b.res), 128'(0));
        check_val("b2b_carry", 128'(out_log[base+i].b.carry), 128'(8'h01));
        check_val("b2b_lat", 128'(out_log[base+i].lat), 128'(2));
      end
      check_val("b2b_spacing", 128'(out_log[base+1].cyc - out_log[base].cyc), 128'(1));
    end

    dir1("add16", 64'hFF, 64'h1, 2'b01, 3'd0, 8'h00, 64'h100, 8'h00, 1'b0);
    dir1("add64", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b11, 3'd0, 8'h00, 64'h0, 8'h01, 1'b0);
    dir1("sub32", 64'h1_0000_0000, 64'h1, 2'b10, 3'd1, 8'h00, 64'h1_FFFF_FFFF, 8'h01, 1'b0);
    dir1("sbc32", 64'h1_0000_0000, 64'h1, 2'b10, 3'd4, 8'h02, 64'h0_FFFF_FFFF, 8'h01, 1'b0);
    dir1("sadd8", 64'h807F, 64'hFF01, 2'b00, 3'd6, 8'h00, 64'h807F, 8'h02, 1'b1);
    dir1("add8", 64'h807F, 64'hFF01, 2'b00, 3'd0, 8'h00, 64'h7F80, 8'h02, 1'b0);
    dir1("rsub8", 64'h5, 64'h3, 2'b00, 3'd2, 8'h00, 64'hFE, 8'h01, 1'b0);
    dir1("saddu16", 64'hFFF0, 64'h20, 2'b01, 3'd5, 8'h00, 64'hFFFF, 8'h01, 1'b1);
    dir1("ssub8", 64'h80, 64'h1, 2'b00, 3'd7, 8'h00, 64'h80, 8'h00, 1'b1);
    dir1("adc8", 64'hFF, 64'h0, 2'b00, 3'd3, 8'h01, 64'h0, 8'h01, 1'b0);

    // backpressure: two beats fill the pipe, the third waits
    out_ready = 1'b0;
    base = out_log.size();
    send(64'h10, 64'h1, 2'b00, 3'd0, 8'h00);
    send(64'h20, 64'h1, 2'b00, 3'd0, 8'h00);
    fork
      send(64'h30, 64'h1, 2'b00, 3'd0, 8'h00);
      begin
        repeat (3) @(negedge clk);
        check_val("bp_in_ready", 128'(in_ready), 128'(0));
        check_val("bp_out_valid", 128'(out_valid), 128'(1));
        check_val("bp_hold_res", 128'(out_result), 128'(64'h11));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_log(base + 3);
    if (out_log.size() >= base + 3) begin
      check_val("bp_order0", 128'(out_log[base].b.res), 128'(64'h11));
      check_val("bp_order1", 128'(out_log[base+1].b.res), 128'(64'h21));
      check_val("bp_order2", 128'(out_log[base+2].b.res), 128'(64'h31));
      check_val("bp_rate", 128'(out_log[base+2].cyc - out_log[base].cyc), 128'(2));
    end

    // reset with two beats in flight
    out_ready = 1'b0;
    send(64'h40, 64'h2, 2'b00, 3'd0, 8'h00);
    send(64'h50, 64'h2, 2'b00, 3'd0, 8'h00);
    check_val("rst_pre_valid", 128'(out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    check_val("rst_async_valid", 128'(out_valid), 128'(0));
    check_val("rst_async_result", 128'(out_result), 128'(0));
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    base = out_log.size();
    dir1("post_rst", 64'h1234, 64'h1111, 2'b01, 3'd0, 8'h00, 64'h2345, 8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check_val("no_stale", 128'(out_log.size()), 128'(base + 1));

    // randomized traffic with random downstream stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(pick(), pick(), 2'($urandom_range(3)), 3'($urandom_range(7)), 8'($urandom()));
          if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge clk);
    check_val("drain", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
